// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types for the writeback trace checker.
//   trace_entry_t : one captured writeback {pc, rd, value} (69 bits)
//   chk_state_e   : checker verdict state (RUN / PASS / FAIL)
//   chk_err_e     : first-failure cause
// The struct field for the destination register is called rd because "reg"
// is a reserved word.
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] value;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } chk_err_e;

  // Full-entry equality: pc, destination register and write data.
  function automatic logic entry_match(trace_entry_t a, trace_entry_t b);
    return (a == b);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// -----------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO of trace_entry_t, DEPTH entries (power of two, >= 2).
// Ports:
//   clk, rst   clock and asynchronous active-high reset (empties the FIFO)
//   push, din  write an entry (ignored when full unless popping the same cycle)
//   pop        drop the head entry (ignored when empty)
//   head       current head entry, valid whenever !empty
//   full/empty occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// -----------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  trace_entry_t din,
  input  logic         pop,
  output trace_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t   mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           push_ok;
  logic           pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: emptiness is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_trace_checker.sv
// -----------------------------------------------------------------------------
// wb_trace_checker
// Checks the CPU writeback debug trace against a golden trace.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   debug_wb_have_inst/pc/ena/reg/value   CPU writeback trace
//   ref_valid/ref_ready       golden-entry handshake
//   ref_pc/ref_reg/ref_value/ref_last     golden entry, ref_last marks the end
//   state                     RUN=0, PASS=1, FAIL=2 (sticky until rst)
//   err_code                  NONE=0, MISMATCH=1, OVERFLOW=2, TIMEOUT=3
//   retire_cnt, match_cnt     running counters (frozen outside RUN)
//   err_pc, err_exp_*, err_act_*          first-failure record
// Qualified writebacks (ena and rd != x0) are queued so the golden source
// may stall; each handshake pops and compares one entry.
// -----------------------------------------------------------------------------
module wb_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debug_wb_have_inst,
  input  logic [31:0]      debug_wb_pc,
  input  logic             debug_wb_ena,
  input  logic [4:0]       debug_wb_reg,
  input  logic [31:0]      debug_wb_value,
  input  logic             ref_valid,
  output logic             ref_ready,
  input  logic [31:0]      ref_pc,
  input  logic [31:0]      ref_value,
  input  logic [4:0]       ref_reg,
  input  logic             ref_last,
  output logic [1:0]       state,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_exp_value,
  output logic [31:0]      err_act_value,
  output logic [4:0]       err_exp_reg,
  output logic [4:0]       err_act_reg
);

  // Idle count at which the next idle edge hits the timeout.
  localparam logic [31:0] IDLE_LIMIT = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  chk_state_e       state_reg, state_next;
  chk_err_e         err_code_reg, err_code_next;
  logic [CNT_W-1:0] retire_cnt_reg, match_cnt_reg;
  logic [31:0]      idle_cnt_reg;
  logic [31:0]      err_pc_reg, err_pc_next;
  logic [31:0]      err_exp_value_reg, err_exp_value_next;
  logic [31:0]      err_act_value_reg, err_act_value_next;
  logic [4:0]       err_exp_reg_reg, err_exp_reg_next;
  logic [4:0]       err_act_reg_reg, err_act_reg_next;

  trace_entry_t     wb_entry, ref_entry, head;
  logic             fifo_full, fifo_empty;
  logic             in_run, qualified, handshake, is_match;
  logic             overflow, timeout_hit;

  assign in_run    = (state_reg == ST_RUN);
  assign qualified = in_run & debug_wb_have_inst & debug_wb_ena & (debug_wb_reg != 5'd0);
  assign ref_ready = in_run & ~fifo_empty;
  assign handshake = ref_valid & ref_ready;
  assign wb_entry  = {debug_wb_pc, debug_wb_reg, debug_wb_value};
  assign ref_entry = {ref_pc, ref_reg, ref_value};
  assign is_match  = entry_match(head, ref_entry);
  assign overflow  = qualified & fifo_full & ~handshake;
  assign timeout_hit = (TIMEOUT != 0) && in_run && !debug_wb_have_inst &&
                       (idle_cnt_reg == IDLE_LIMIT);

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (qualified),
    .din   (wb_entry),
    .pop   (handshake),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_RUN;
      err_code_reg      <= ERR_NONE;
      err_pc_reg        <= '0;
      err_exp_value_reg <= '0;
      err_act_value_reg <= '0;
      err_exp_reg_reg   <= '0;
      err_act_reg_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      err_code_reg      <= err_code_next;
      err_pc_reg        <= err_pc_next;
      err_exp_value_reg <= err_exp_value_next;
      err_act_value_reg <= err_act_value_next;
      err_exp_reg_reg   <= err_exp_reg_next;
      err_act_reg_reg   <= err_act_reg_next;
    end
  end

  // Verdict and error record. Priority inside RUN: mismatch, matched last
  // entry, overflow, timeout. The record only changes on the RUN->FAIL edge.
  always_comb begin
    state_next         = state_reg;
    err_code_next      = err_code_reg;
    err_pc_next        = err_pc_reg;
    err_exp_value_next = err_exp_value_reg;
    err_act_value_next = err_act_value_reg;
    err_exp_reg_next   = err_exp_reg_reg;
    err_act_reg_next   = err_act_reg_reg;
    if (in_run) begin
      if (handshake && !is_match) begin
        state_next         = ST_FAIL;
        err_code_next      = ERR_MISMATCH;
        err_pc_next        = head.pc;
        err_exp_value_next = ref_value;
        err_act_value_next = head.value;
        err_exp_reg_next   = ref_reg;
        err_act_reg_next   = head.rd;
      end else if (handshake && ref_last) begin
        state_next = ST_PASS;
      end else if (overflow) begin
        state_next    = ST_FAIL;
        err_code_next = ERR_OVERFLOW;
        err_pc_next   = debug_wb_pc;
      end else if (timeout_hit) begin
        state_next    = ST_FAIL;
        err_code_next = ERR_TIMEOUT;
        err_pc_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_reg <= '0;
      match_cnt_reg  <= '0;
      idle_cnt_reg   <= '0;
    end else if (in_run) begin
      if (debug_wb_have_inst)     retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
      if (handshake && is_match)  match_cnt_reg  <= match_cnt_reg + CNT_W'(1);
      idle_cnt_reg <= debug_wb_have_inst ? 32'd0 : idle_cnt_reg + 32'd1;
    end
  end

  assign state         = state_reg;
  assign err_code      = err_code_reg;
  assign retire_cnt    = retire_cnt_reg;
  assign match_cnt     = match_cnt_reg;
  assign err_pc        = err_pc_reg;
  assign err_exp_value = err_exp_value_reg;
  assign err_act_value = err_act_value_reg;
  assign err_exp_reg   = err_exp_reg_reg;
  assign err_act_reg   = err_act_reg_reg;

endmodule

// File: tb/tb_wb_trace_checker.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_checker
// Scoreboard bench: expectations are queued while stimulus is set up for a
// cycle and popped/compared right after the clock edge that should produce
// them. Inputs change and outputs are sampled 1 time unit after posedge.
// -----------------------------------------------------------------------------
module tb_wb_trace_checker;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             have_inst, wb_ena, ref_valid, ref_ready, ref_last;
  logic [31:0]      wb_pc, wb_value, ref_pc, ref_value;
  logic [4:0]       wb_reg, ref_reg;
  logic [1:0]       state, err_code;
  logic [CNT_W-1:0] retire_cnt, match_cnt;
  logic [31:0]      err_pc, err_exp_value, err_act_value;
  logic [4:0]       err_exp_reg, err_act_reg;

  always #5 clk = ~clk;

  wb_trace_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rst                (rst),
    .debug_wb_have_inst (have_inst),
    .debug_wb_pc        (wb_pc),
    .debug_wb_ena       (wb_ena),
    .debug_wb_reg       (wb_reg),
    .debug_wb_value     (wb_value),
    .ref_valid          (ref_valid),
    .ref_ready          (ref_ready),
    .ref_pc             (ref_pc),
    .ref_value          (ref_value),
    .ref_reg            (ref_reg),
    .ref_last           (ref_last),
    .state              (state),
    .err_code           (err_code),
    .retire_cnt         (retire_cnt),
    .match_cnt          (match_cnt),
    .err_pc             (err_pc),
    .err_exp_value      (err_exp_value),
    .err_act_value      (err_act_value),
    .err_exp_reg        (err_exp_reg),
    .err_act_reg        (err_act_reg)
  );

  typedef enum int {S_STATE, S_ERR, S_MATCH, S_RETIRE, S_READY,
                    S_EPC, S_EEV, S_EAV, S_EER, S_EAR} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [31:0] observe(sel_e s);
    case (s)
      S_STATE:  return {30'd0, state};
      S_ERR:    return {30'd0, err_code};
      S_MATCH:  return match_cnt;
      S_RETIRE: return retire_cnt;
      S_READY:  return {31'd0, ref_ready};
      S_EPC:    return err_pc;
      S_EEV:    return err_exp_value;
      S_EAV:    return err_act_value;
      S_EER:    return {27'd0, err_exp_reg};
      default:  return {27'd0, err_act_reg};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic expect_out(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic expect_reset(input string tag);
    expect_out({tag, ".state"},  S_STATE,  0);
    expect_out({tag, ".err"},    S_ERR,    0);
    expect_out({tag, ".match"},  S_MATCH,  0);
    expect_out({tag, ".retire"}, S_RETIRE, 0);
    expect_out({tag, ".ready"},  S_READY,  0);
    expect_out({tag, ".epc"},    S_EPC,    0);
    expect_out({tag, ".eev"},    S_EEV,    0);
    expect_out({tag, ".eav"},    S_EAV,    0);
    expect_out({tag, ".eer"},    S_EER,    0);
    expect_out({tag, ".ear"},    S_EAR,    0);
  endtask

  task automatic clear_in();
    have_inst = 1'b0; wb_ena = 1'b0; wb_reg = '0; wb_pc = '0; wb_value = '0;
    ref_valid = 1'b0; ref_last = 1'b0; ref_reg = '0; ref_pc = '0; ref_value = '0;
  endtask

  task automatic set_wb(input logic [31:0] pc, input int ena, input logic [31:0] rd,
                        input logic [31:0] v);
    have_inst = 1'b1; wb_pc = pc; wb_ena = (ena != 0); wb_reg = rd[4:0]; wb_value = v;
  endtask

  task automatic set_ref(input logic [31:0] pc, input logic [31:0] rd,
                         input logic [31:0] v, input int last);
    ref_valid = 1'b1; ref_pc = pc; ref_reg = rd[4:0]; ref_value = v; ref_last = (last != 0);
  endtask

  // One clock: edge, settle, compare queued expectations, release inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    score();
    clear_in();
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic apply_reset(input string tag);
    rst = 1'b1;
    clear_in();
    #1;
    expect_reset(tag);
    score();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    clear_in();
    #2;

    // ---- match run with overlapped push/pop ----
    apply_reset("rst0");
    set_wb(32'h0, 1, 1, 1);
    tick();
    set_wb(32'h4, 1, 2, 2); set_ref(32'h0, 1, 1, 0);
    expect_out("match.c2.cnt", S_MATCH, 1);
    expect_out("match.c2.ready", S_READY, 1);
    tick();
    set_wb(32'h8, 1, 3, 3); set_ref(32'h4, 2, 2, 0);
    tick();
    set_ref(32'h8, 3, 3, 1);
    expect_out("match.state", S_STATE, 1);
    expect_out("match.cnt", S_MATCH, 3);
    expect_out("match.err", S_ERR, 0);
    expect_out("match.retire", S_RETIRE, 3);
    expect_out("match.ready", S_READY, 0);
    tick();

    // ---- value mismatch ----
    apply_reset("rst1");
    set_wb(32'h8, 1, 5, 32'h10);
    tick();
    set_ref(32'h8, 5, 32'h11, 0);
    expect_out("mis.state", S_STATE, 2);
    expect_out("mis.err", S_ERR, 1);
    expect_out("mis.epc", S_EPC, 32'h8);
    expect_out("mis.eev", S_EEV, 32'h11);
    expect_out("mis.eav", S_EAV, 32'h10);
    expect_out("mis.eer", S_EER, 5);
    expect_out("mis.ear", S_EAR, 5);
    expect_out("mis.match", S_MATCH, 0);
    expect_out("mis.ready", S_READY, 0);
    tick();
    // FAIL is sticky and freezes counters.
    set_wb(32'hC, 1, 6, 6);
    expect_out("mis.hold.state", S_STATE, 2);
    expect_out("mis.hold.retire", S_RETIRE, 1);
    expect_out("mis.hold.epc", S_EPC, 32'h8);
    tick();

    // ---- filtering: x0 and ena=0 retire but are not queued ----
    apply_reset("rst2");
    set_wb(32'h0, 1, 0, 32'h99);  tick();
    set_wb(32'h4, 0, 4, 32'h44);  tick();
    set_wb(32'h8, 1, 6, 6);       tick();
    set_wb(32'hC, 0, 0, 0);       tick();
    set_wb(32'h10, 1, 7, 7);
    expect_out("filt.retire", S_RETIRE, 5);
    tick();
    set_ref(32'h8, 6, 6, 0);       tick();
    set_ref(32'h10, 7, 7, 1);
    expect_out("filt.state", S_STATE, 1);
    expect_out("filt.match", S_MATCH, 2);
    expect_out("filt.err", S_ERR, 0);
    tick();

    // ---- overflow on the 9th push with no pop ----
    apply_reset("rst3");
    for (int i = 0; i < 8; i++) begin
      set_wb(32'h100 + 4 * i, 1, 1, i);
      if (i == 7) expect_out("ovf.pre.state", S_STATE, 0);
      tick();
    end
    set_wb(32'h120, 1, 1, 8);
    expect_out("ovf.state", S_STATE, 2);
    expect_out("ovf.err", S_ERR, 2);
    expect_out("ovf.epc", S_EPC, 32'h120);
    expect_out("ovf.ready", S_READY, 0);
    tick();

    // ---- 9th push with a pop in the same cycle: no overflow ----
    apply_reset("rst4");
    for (int i = 0; i < 8; i++) begin
      set_wb(32'h100 + 4 * i, 1, 1, i);
      tick();
    end
    set_wb(32'h120, 1, 1, 8); set_ref(32'h100, 1, 0, 0);
    expect_out("full.pp.state", S_STATE, 0);
    expect_out("full.pp.err", S_ERR, 0);
    expect_out("full.pp.match", S_MATCH, 1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      set_ref(32'h100 + 4 * i, 1, i, (i == 8) ? 1 : 0);
      tick();
    end
    expect_out("full.drain.state", S_STATE, 1);
    expect_out("full.drain.match", S_MATCH, 9);
    score();

    // ---- timeout after 16 idle cycles ----
    apply_reset("rst5");
    for (int i = 0; i < 15; i++) tick();
    expect_out("to.pre.state", S_STATE, 0);
    score();
    expect_out("to.state", S_STATE, 2);
    expect_out("to.err", S_ERR, 3);
    expect_out("to.epc", S_EPC, 0);
    tick();

    // ---- a retire on cycle 15 restarts the idle count ----
    apply_reset("rst6");
    for (int i = 0; i < 14; i++) tick();
    set_wb(32'h40, 0, 0, 0);
    tick();
    for (int i = 0; i < 15; i++) tick();
    expect_out("to2.pre.state", S_STATE, 0);
    expect_out("to2.retire", S_RETIRE, 1);
    score();
    expect_out("to2.state", S_STATE, 2);
    expect_out("to2.err", S_ERR, 3);
    tick();

    // ---- reset mid-run with 4 entries queued ----
    apply_reset("rst7");
    for (int i = 0; i < 4; i++) begin
      set_wb(32'h200 + 4 * i, 1, 9, 32'hAA00 + i);
      tick();
    end
    apply_reset("midrst");
    set_wb(32'h0, 1, 1, 32'h55);  tick();
    set_wb(32'h4, 1, 2, 32'h66);  tick();
    set_ref(32'h0, 1, 32'h55, 0); tick();
    set_ref(32'h4, 2, 32'h66, 1);
    expect_out("post.state", S_STATE, 1);
    expect_out("post.match", S_MATCH, 2);
    expect_out("post.retire", S_RETIRE, 2);
    expect_out("post.err", S_ERR, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Consumes the CPU's writeback debug trace (`debug_wb_*`) and checks it entry by entry against a golden trace streamed in over a valid/ready handshake. Qualifying writebacks are buffered in a small FIFO so the golden source can stall. The block latches a pass or fail verdict, the first-failure record and running counters. It sits beside the CPU in the simulation and FPGA self-check top, on the receiving end of the trace port.

## Interface
- `DEPTH`, 8: capture FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: maximum idle cycles with no retired instruction; 0 disables the timeout.
- `CNT_W`, 32: counter width.

- `clk`  in  1  clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `debug_wb_have_inst`  in  1  a valid instruction is in WB this cycle.
- `debug_wb_pc`  in  32  PC of the WB instruction.
- `debug_wb_ena`  in  1  register-file write enable.
- `debug_wb_reg`  in  5  destination register.
- `debug_wb_value`  in  32  write data.
- `ref_valid`  in  1  a golden entry is presented.
- `ref_ready`  out  1  the checker accepts the golden entry this cycle.
- `ref_pc`, `ref_value`  in  32 each  golden PC and write data.
- `ref_reg`  in  5  golden destination register.
- `ref_last`  in  1  the presented entry is the final golden entry.
- `state`  out  2  RUN=0, PASS=1, FAIL=2.
- `err_code`  out  2  NONE=0, MISMATCH=1, OVERFLOW=2, TIMEOUT=3.
- `retire_cnt`  out  CNT_W  retired instructions counted in RUN.
- `match_cnt`  out  CNT_W  successful compares.
- `err_pc`  out  32  PC of the first failure.
- `err_exp_value`, `err_act_value`  out  32 each  golden and DUT data at the first failure.
- `err_exp_reg`, `err_act_reg`  out  5 each  golden and DUT register at the first failure.

## Operation
- **Capture.** While in RUN, an event is qualified when `debug_wb_have_inst & debug_wb_ena & (debug_wb_reg != 0)`. Each qualified event pushes {pc, reg, value} into the FIFO.
- **Retire count.** `retire_cnt` increments on every `debug_wb_have_inst` while in RUN.
- **Ready.** `ref_ready = (state == RUN) & !fifo_empty`. It is combinational from registered state only.
- **Compare.** A compare happens on a handshake (`ref_valid & ref_ready`). At that edge the FIFO head is popped and compared on pc, reg and value.
  - Full equality: `match_cnt` increments. If `ref_last` is also set, the state goes to PASS.
  - Any field differs: the state goes to FAIL with `err_code` = MISMATCH. `err_pc` takes the FIFO head's pc. The `err_exp_*` fields take the `ref_*` values and the `err_act_*` fields take the FIFO head's values.
- **Overflow.** A push while the FIFO is full and no pop happens in the same cycle goes to FAIL with OVERFLOW. `err_pc` takes `debug_wb_pc`. Push and pop together when full is legal: no overflow, and the count is unchanged.
- **Timeout.** The idle counter clears on `debug_wb_have_inst` and otherwise increments in RUN. When it reaches `TIMEOUT` the state goes to FAIL with TIMEOUT and `err_pc` = 0.
- **Same-cycle priority.** MISMATCH beats OVERFLOW, which beats TIMEOUT. A matched `ref_last` beats OVERFLOW and TIMEOUT.
- **Terminal states.** PASS and FAIL hold until `rst`. In them: no capture, no pops, counters frozen, `ref_ready` = 0. The error record is written only on entry to FAIL.
- **Reset values.** `state` = RUN, `err_code` = NONE, all counters and `err_*` = 0, FIFO empty, `ref_ready` = 0.

## Timing
- A qualified event at edge N is at the FIFO head at edge N+1. The earliest compare handshake happens at edge N+1.
- `state`, `err_*` and `match_cnt` update at the handshake edge and are visible the following cycle.
- Sustained throughput is one push and one pop per cycle.
- `rst` asserted mid-run clears everything asynchronously, including FIFO contents. The first capture can happen at the first edge after deassertion.

## Structure
- **Package `trace_pkg`:**
  - `trace_entry_t` struct {pc[31:0], reg[4:0], value[31:0]}, 69 bits.
  - `chk_state_e` enum: RUN, PASS, FAIL.
  - `chk_err_e` enum: NONE, MISMATCH, OVERFLOW, TIMEOUT.
- **Sub-module `trace_fifo`:** synchronous FIFO of `trace_entry_t`, `DEPTH` entries. Ports: push, pop, head, full, empty. Pointers are log2(DEPTH)+1 bits wide and wrap naturally. Registered storage.
- **Top level:** FSM, counters and the error record.

## Test plan
- **Match run:** 3 writebacks (x1 = 1, x2 = 2, x3 = 3) with matching golden entries, the last one with `ref_last` → PASS, `match_cnt` = 3, `err_code` = 0.
- **Value mismatch:** DUT pc = 0x8, x5 = 0x10; golden value 0x11 → FAIL with MISMATCH, `err_pc` = 0x8, `err_exp_value` = 0x11, `err_act_value` = 0x10.
- **Filtering:** writes to x0 and writebacks with `debug_wb_ena` = 0 are not pushed; `retire_cnt` still counts them (5 retires, 2 pushes → `match_cnt` = 2).
- **Overflow:** `DEPTH` = 8, `ref_valid` held 0, 9 qualified events → FAIL with OVERFLOW on the 9th, `err_pc` = the 9th event's pc. A second run with a pop on the 9th cycle → no error.
- **Timeout:** `TIMEOUT` = 16, no `debug_wb_have_inst` for 16 cycles → FAIL with TIMEOUT. A single retire at cycle 15 restarts the count.
- **Reset:** `rst` pulsed mid-run with the FIFO holding 4 entries → all outputs at reset values; the next matching sequence passes.
